breadboard_sweeper: RTL and testbench
=====================================

Name: breadboard_sweeper

Overview:
- Sequential stimulus/response engine for the 4-input, 10-output combinational breadboard logic block.
- Drives all 16 input combinations w,x,y,z in index order (index = 8w+4x+2y+z), waits a programmable settle time, and captures the 10 response bits per vector.
- Stores the captured responses in a 16x10 buffer and folds them into a rolling signature, so silicon and FPGA checks no longer depend on a simulation-only display loop.

Parameters:
- SETTLE_CYCLES, 4, cycles each vector is held before sampling; legal range 1..255.
- RESP_W, 10, response width (r0..r9).

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a sweep.
- abort  in  1  one-cycle pulse; terminates a sweep in progress.
- w, x, y, z  out  1 each  registered stimulus to the logic block.
- r_i  in  RESP_W  response from the logic block; bit k = rk.
- busy  out  1  high while a sweep is in progress.
- done  out  1  high from sweep completion until the next start.
- vec_idx  out  4  index of the vector currently driven.
- rd_addr  in  4  buffer read address.
- rd_data  out  RESP_W  buffer read data, combinational from rd_addr.
- signature  out  RESP_W  rolling signature of the sweep.
- mismatch_cnt  out  5  golden-compare failures; present only with the optional feature.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - w, x, y, z, busy, done, vec_idx, signature and mismatch_cnt all go to 0.
  - The settle counter goes to 0.
  - Buffer contents are not reset; they are undefined until the first sweep.
- States: IDLE, DRIVE, SAMPLE, DONE.
- IDLE / DONE:
  - start=1 -> DRIVE. On the same edge: vec_idx=0, wxyz=0000, signature=0, mismatch_cnt=0, done=0, busy=1.
- DRIVE:
  - wxyz = vec_idx, registered.
  - The settle counter counts SETTLE_CYCLES cycles, then the state moves to SAMPLE.
- SAMPLE (one cycle; on its closing edge):
  - mem[vec_idx] <= r_i.
  - signature <= {signature[RESP_W-2:0], signature[RESP_W-1]} ^ r_i.
  - If vec_idx == 15: go to DONE, busy=0, done=1.
  - Otherwise: vec_idx += 1 and go to DRIVE with the counter cleared.
- Timing:
  - Each vector occupies exactly SETTLE_CYCLES+1 cycles.
  - done rises 16*(SETTLE_CYCLES+1) edges after the start edge.
- start while busy: ignored, with no restart or glitch.
- abort while busy: next edge goes to IDLE, busy=0, done=0, wxyz=0000, vec_idx=0. Buffer entries already written are kept.
- abort in IDLE or DONE: no effect.
- start and abort asserted in the same cycle:
  - While busy, abort wins.
  - While idle, start wins.
- Wrap-around: vec_idx never increments past 15.
- Reading: rd_data reflects mem[rd_addr] at all times, including mid-sweep. Entries not yet overwritten in the current sweep hold the previous sweep's data.
- Reset mid-sweep: immediate return to IDLE with all outputs at their reset values. No partial done.
- r_i is treated as synchronous: the logic block is combinational from registered wxyz, and SETTLE_CYCLES >= 1 guarantees a stable sample.

Optional Feature:
- Macro: BREADBOARD_SWEEP_CHECK_EN.
- Defined:
  - In SAMPLE, r_i[3:0] is compared against internal golden functions of the current w,x,y,z:
    - f0 = wx' + xyz' + y'z
    - f1 = wx + xz' + yz
    - f2 = yz + w'y'z' + w'xy' + xy'z' + wx'z + wx'y
    - f3 = w'xy'z' + x'z + w'x'y + wy'z + wx'y'
  - mismatch_cnt increments by 1 per vector with any differing bit, saturating at 16.
  - Bits r4..r9 are not checked.
- Undefined: the compare logic is absent and mismatch_cnt is tied to 0.

Decomposition:
- Shared package breadboard_pkg holds:
  - sweep state enum: IDLE, DRIVE, SAMPLE, DONE;
  - NUM_VECTORS=16;
  - RESP_W default;
  - golden functions f0..f3 as functions, used under the macro and reusable by benches.
- One sub-module: breadboard_resp_buf, a 16xRESP_W register file with one synchronous write port and one combinational read port.

Test Plan:
- Loopback DUT (r_i = {6'b0,w,x,y,z}), SETTLE_CYCLES=4, pulse start -> done rises 80 edges later; rd_addr=5 -> rd_data=10'b0000000101; rd_addr=15 -> 10'b0000001111.
- Golden-correct DUT with BREADBOARD_SWEEP_CHECK_EN -> mismatch_cnt=0 after done.
- Golden DUT with r0 stuck at 0 -> mismatch_cnt=9 (failing vectors 1,5,6,8,9,10,11,13,14).
- Pulse abort at vector 7 -> busy=0 next edge, done=0, wxyz=0000; mem[0..6] hold new data; new start completes normally.
- start pulsed at vectors 3 and 10 while busy -> ignored, done timing unchanged at 80 edges.
- rst_n low mid-sweep at vector 9 -> all outputs 0 immediately, state IDLE; a subsequent start produces the same signature as a clean sweep.

Source files
------------

// File: rtl/breadboard_sweeper_pkg.sv
// Shared types, sizes and golden logic functions for the breadboard sweeper.
// The golden functions are only instantiated when BREADBOARD_SWEEP_CHECK_EN is defined.
package breadboard_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } sweep_state_t;

  localparam int NUM_VECTORS    = 16;
  localparam int RESP_W_DEFAULT = 10;

  function automatic logic golden_f0(input logic w, input logic x, input logic y, input logic z);
    return (w & ~x) | (x & y & ~z) | (~y & z);
  endfunction

  function automatic logic golden_f1(input logic w, input logic x, input logic y, input logic z);
    return (w & x) | (x & ~z) | (y & z);
  endfunction

  function automatic logic golden_f2(input logic w, input logic x, input logic y, input logic z);
    return (y & z) | (~w & ~y & ~z) | (~w & x & ~y) | (x & ~y & ~z)
         | (w & ~x & z) | (w & ~x & y);
  endfunction

  function automatic logic golden_f3(input logic w, input logic x, input logic y, input logic z);
    return (~w & x & ~y & ~z) | (~x & z) | (~w & ~x & y) | (w & ~y & z) | (w & ~x & ~y);
  endfunction

  // Index order is {w,x,y,z}; result is {f3,f2,f1,f0} to line up with r_i[3:0].
  function automatic logic [3:0] golden_resp(input logic [3:0] v);
    return {golden_f3(v[3], v[2], v[1], v[0]), golden_f2(v[3], v[2], v[1], v[0]),
            golden_f1(v[3], v[2], v[1], v[0]), golden_f0(v[3], v[2], v[1], v[0])};
  endfunction

endpackage

// File: rtl/breadboard_sweeper_if.sv
// Control, stimulus, response and readback bundle between a sweep controller and its user.
interface breadboard_sweeper_if #(
  parameter int RESP_W = 10
);
  logic              start;
  logic              abort;
  logic              w;
  logic              x;
  logic              y;
  logic              z;
  logic [RESP_W-1:0] r_i;
  logic              busy;
  logic              done;
  logic [3:0]        vec_idx;
  logic [3:0]        rd_addr;
  logic [RESP_W-1:0] rd_data;
  logic [RESP_W-1:0] signature;
  logic [4:0]        mismatch_cnt;

  modport master (
    output start, abort, r_i, rd_addr,
    input  w, x, y, z, busy, done, vec_idx, rd_data, signature, mismatch_cnt
  );

  modport slave (
    input  start, abort, r_i, rd_addr,
    output w, x, y, z, busy, done, vec_idx, rd_data, signature, mismatch_cnt
  );
endinterface

// File: rtl/breadboard_sweeper_resp_buf.sv
// 16-entry response buffer: one synchronous write port, one combinational read port.
// Deliberately not reset; contents are meaningful only once a sweep has written them.
module breadboard_resp_buf
  import breadboard_pkg::*;
#(
  parameter int RESP_W = RESP_W_DEFAULT
) (
  input  logic              clk,
  input  logic              i_wr_en,
  input  logic [3:0]        i_wr_addr,
  input  logic [RESP_W-1:0] i_wr_data,
  input  logic [3:0]        i_rd_addr,
  output logic [RESP_W-1:0] o_rd_data
);

  logic [RESP_W-1:0] r_mem [NUM_VECTORS];

  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/breadboard_sweeper.sv
// Sweeps all 16 {w,x,y,z} vectors, captures responses and folds them into a signature.
// Optional golden compare of r_i[3:0] enabled by BREADBOARD_SWEEP_CHECK_EN.
//
// state  | meaning
// IDLE   | waiting for start, outputs parked
// DRIVE  | holding vec_idx on wxyz for SETTLE_CYCLES cycles
// SAMPLE | one cycle; capture r_i into buffer and signature
// DONE   | sweep complete, done held until next start
module breadboard_sweeper
  import breadboard_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int RESP_W        = RESP_W_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  breadboard_sweeper_if.slave  bus
);

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

  sweep_state_t      r_state;
  logic [7:0]        r_settle_cnt;
  logic [3:0]        r_vec_idx;
  logic [3:0]        r_wxyz;
  logic              r_busy;
  logic              r_done;
  logic [RESP_W-1:0] r_sig;
  logic [4:0]        r_mis_cnt;
  logic              w_wr_en;
  logic [RESP_W-1:0] w_rd_data;

  // An abort arriving in SAMPLE wins, so that vector is not stored.
  assign w_wr_en = (r_state == SAMPLE) && !bus.abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_settle_cnt <= '0;
      r_vec_idx    <= '0;
      r_wxyz       <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_sig        <= '0;
      r_mis_cnt    <= '0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (bus.start) begin
            r_state      <= DRIVE;
            r_settle_cnt <= '0;
            r_vec_idx    <= '0;
            r_wxyz       <= '0;
            r_sig        <= '0;
            r_mis_cnt    <= '0;
            r_done       <= 1'b0;
            r_busy       <= 1'b1;
          end
        end
        DRIVE, SAMPLE: begin
          if (bus.abort) begin
            r_state      <= IDLE;
            r_settle_cnt <= '0;
            r_vec_idx    <= '0;
            r_wxyz       <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
          end else if (r_state == DRIVE) begin
            if (r_settle_cnt == SETTLE_LAST) begin
              r_state      <= SAMPLE;
              r_settle_cnt <= '0;
            end else begin
              r_settle_cnt <= r_settle_cnt + 8'd1;
            end
          end else begin
            r_sig <= {r_sig[RESP_W-2:0], r_sig[RESP_W-1]} ^ bus.r_i;
`ifdef BREADBOARD_SWEEP_CHECK_EN
            if ((golden_resp(r_wxyz) != bus.r_i[3:0]) && (r_mis_cnt != 5'd16))
              r_mis_cnt <= r_mis_cnt + 5'd1;
`endif
            if (r_vec_idx == 4'd15) begin
              r_state <= DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state      <= DRIVE;
              r_settle_cnt <= '0;
              r_vec_idx    <= r_vec_idx + 4'd1;
              r_wxyz       <= r_vec_idx + 4'd1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  breadboard_resp_buf #(.RESP_W(RESP_W)) u_resp_buf (
    .clk       (clk),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (r_vec_idx),
    .i_wr_data (bus.r_i),
    .i_rd_addr (bus.rd_addr),
    .o_rd_data (w_rd_data)
  );

  assign bus.w            = r_wxyz[3];
  assign bus.x            = r_wxyz[2];
  assign bus.y            = r_wxyz[1];
  assign bus.z            = r_wxyz[0];
  assign bus.busy         = r_busy;
  assign bus.done         = r_done;
  assign bus.vec_idx      = r_vec_idx;
  assign bus.rd_data      = w_rd_data;
  assign bus.signature    = r_sig;
`ifdef BREADBOARD_SWEEP_CHECK_EN
  assign bus.mismatch_cnt = r_mis_cnt;
`else
  assign bus.mismatch_cnt = 5'd0;
`endif

endmodule

// File: tb/tb_breadboard_sweeper.sv
// Directed bench for breadboard_sweeper: loopback, golden and faulty logic-block models,
// abort, ignored start, start/abort priority and mid-sweep reset.
module tb_breadboard_sweeper;

  localparam int RW = 10;
  // Hand-derived truth tables of f0..f3, bit i = value at index i = 8w+4x+2y+z.
  localparam logic [15:0] T_F0 = 16'h6F62;
  localparam logic [15:0] T_F1 = 16'hF8D8;
  localparam logic [15:0] T_F2 = 16'h9EB9;
  localparam logic [15:0] T_F3 = 16'h2B1E;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   mode  = 0;   // 0 loopback, 1 golden block, 2 golden block with r0 stuck at 0
  int   n_vec  = 0;
  int   n_fail = 0;
  int   edges;
  bit   p3, p10;

  breadboard_sweeper_if #(.RESP_W(RW)) bif ();

  breadboard_sweeper #(.SETTLE_CYCLES(4), .RESP_W(RW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  always #5 clk = ~clk;

  function automatic logic [RW-1:0] model_resp(input int m, input logic [3:0] v);
    logic [3:0] g;
    g = {T_F3[v], T_F2[v], T_F1[v], T_F0[v]};
    if (m == 0) return {6'b0, v};
    if (m == 2) g[0] = 1'b0;
    return {~v[0], v[1], v[2], v[3], v[0], ~v[1], g};
  endfunction

  function automatic logic [RW-1:0] sig_model(input int m);
    logic [RW-1:0] s;
    s = '0;
    for (int i = 0; i < 16; i++) s = {s[RW-2:0], s[RW-1]} ^ model_resp(m, 4'(i));
    return s;
  endfunction

  always_comb bif.r_i = model_resp(mode, {bif.w, bif.x, bif.y, bif.z});

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_pulse();
    @(negedge clk) bif.start = 1'b1;
    @(negedge clk) bif.start = 1'b0;
  endtask

  task automatic run_to_done(output int n);
    n = 0;
    while (!bif.done && n < 300) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_vec(input logic [3:0] v);
    int n;
    n = 0;
    while (bif.vec_idx !== v && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("reach_vec", 32'(bif.vec_idx), 32'(v));
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"}, 32'(bif.busy), 32'd0);
    chk({tag, "_done"}, 32'(bif.done), 32'd0);
    chk({tag, "_vec"},  32'(bif.vec_idx), 32'd0);
    chk({tag, "_wxyz"}, 32'({bif.w, bif.x, bif.y, bif.z}), 32'd0);
  endtask

  initial begin
    bif.start   = 1'b0;
    bif.abort   = 1'b0;
    bif.rd_addr = 4'd0;
    #1 rst_n = 1'b0;
    #11;
    chk_idle_outputs("reset");
    chk("reset_sig", 32'(bif.signature), 32'd0);
    chk("reset_mis", 32'(bif.mismatch_cnt), 32'd0);
    @(negedge clk) rst_n = 1'b1;

    // Loopback sweep
    mode = 0;
    start_pulse();
    chk("lb_busy", 32'(bif.busy), 32'd1);
    run_to_done(edges);
    chk("lb_done_edges", 32'(edges), 32'd80);
    chk("lb_busy_end", 32'(bif.busy), 32'd0);
    chk("lb_vec_end", 32'(bif.vec_idx), 32'd15);
    chk("lb_sig", 32'(bif.signature), 32'(sig_model(0)));
    bif.rd_addr = 4'd5;
    #1 chk("lb_rd5", 32'(bif.rd_data), 32'h005);
    bif.rd_addr = 4'd15;
    #1 chk("lb_rd15", 32'(bif.rd_data), 32'h00F);
    bif.rd_addr = 4'd0;
    #1 chk("lb_rd0", 32'(bif.rd_data), 32'h000);

    // abort while DONE has no effect
    @(negedge clk) bif.abort = 1'b1;
    @(negedge clk) bif.abort = 1'b0;
    chk("done_abort_done", 32'(bif.done), 32'd1);
    chk("done_abort_busy", 32'(bif.busy), 32'd0);

    // Golden-correct block
    mode = 1;
    start_pulse();
    run_to_done(edges);
    chk("gold_edges", 32'(edges), 32'd80);
    chk("gold_sig", 32'(bif.signature), 32'(sig_model(1)));
    chk("gold_mis", 32'(bif.mismatch_cnt), 32'd0);

    // Golden block with r0 stuck at 0
    mode = 2;
    start_pulse();
    run_to_done(edges);
    chk("stuck_sig", 32'(bif.signature), 32'(sig_model(2)));
`ifdef BREADBOARD_SWEEP_CHECK_EN
    chk("stuck_mis", 32'(bif.mismatch_cnt), 32'd9);
`else
    chk("stuck_mis", 32'(bif.mismatch_cnt), 32'd0);
`endif

    // Abort at vector 7: entries 0..6 rewritten, 7..15 keep the stuck-r0 data
    mode = 0;
    start_pulse();
    wait_vec(4'd7);
    bif.abort = 1'b1;
    @(negedge clk) bif.abort = 1'b0;
    chk_idle_outputs("abort");
    for (int i = 0; i < 16; i++) begin
      bif.rd_addr = 4'(i);
      #1 chk($sformatf("abort_mem%0d", i), 32'(bif.rd_data),
             32'(model_resp((i < 7) ? 0 : 2, 4'(i))));
    end
    repeat (3) @(negedge clk);
    chk("abort_stays_idle", 32'(bif.busy), 32'd0);
    start_pulse();
    run_to_done(edges);
    chk("abort_rerun_edges", 32'(edges), 32'd80);
    chk("abort_rerun_sig", 32'(bif.signature), 32'(sig_model(0)));

    // start pulses at vectors 3 and 10 are ignored
    mode = 1;
    start_pulse();
    edges = 0;
    p3 = 1'b0;
    p10 = 1'b0;
    while (!bif.done && edges < 300) begin
      @(negedge clk);
      edges++;
      bif.start = 1'b0;
      if (bif.vec_idx == 4'd3 && !p3) begin bif.start = 1'b1; p3 = 1'b1; end
      if (bif.vec_idx == 4'd10 && !p10) begin bif.start = 1'b1; p10 = 1'b1; end
    end
    bif.start = 1'b0;
    chk("ign_edges", 32'(edges), 32'd80);
    chk("ign_sig", 32'(bif.signature), 32'(sig_model(1)));

    // start+abort: start wins from DONE, abort wins while busy
    @(negedge clk) begin bif.start = 1'b1; bif.abort = 1'b1; end
    @(negedge clk) begin bif.start = 1'b0; bif.abort = 1'b0; end
    chk("sa_idle_busy", 32'(bif.busy), 32'd1);
    chk("sa_idle_done", 32'(bif.done), 32'd0);
    repeat (7) @(negedge clk);
    bif.start = 1'b1;
    bif.abort = 1'b1;
    @(negedge clk) begin bif.start = 1'b0; bif.abort = 1'b0; end
    chk_idle_outputs("sa_busy");

    // Reset in the middle of vector 9
    mode = 0;
    start_pulse();
    wait_vec(4'd9);
    #2 rst_n = 1'b0;
    #1;
    chk_idle_outputs("mid_rst");
    chk("mid_rst_sig", 32'(bif.signature), 32'd0);
    chk("mid_rst_mis", 32'(bif.mismatch_cnt), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("mid_rst_idle", 32'(bif.busy), 32'd0);
    start_pulse();
    run_to_done(edges);
    chk("mid_rst_edges", 32'(edges), 32'd80);
    chk("mid_rst_sig_clean", 32'(bif.signature), 32'(sig_model(0)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
